// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer
//  Purpose  : Multi-cycle fetch/decode/execute control FSM with PC, IR and
//             retired-instruction counter; issues one-cycle datapath strobes.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 16,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               zero_flag,
    input  logic               mem_ready,
    output logic [ADDR_W-1:0]  pc_addr,
    output logic               ir_enable,
    output logic [INSTR_W-1:0] ir,
    output logic               alu_enable,
    output logic [3:0]         alu_op,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_write,
    output logic               halted,
    output logic [2:0]         state,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] c_OP_ADD   = 4'b0000;
    localparam logic [3:0] c_OP_ALU4  = 4'b0100;
    localparam logic [3:0] c_OP_ALU5  = 4'b0101;
    localparam logic [3:0] c_OP_ALU6  = 4'b0110;
    localparam logic [3:0] c_OP_BEQ   = 4'b0111;
    localparam logic [3:0] c_OP_LOAD  = 4'b1001;
    localparam logic [3:0] c_OP_STORE = 4'b1010;
    localparam logic [3:0] c_OP_JUMP  = 4'b1011;
    localparam logic [3:0] c_OP_HALT  = 4'b1111;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_next;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic [ADDR_W-1:0]   w_target;
    logic [INSTR_W-1:0]  r_ir;
    logic [CNT_W-1:0]    r_retired;
    logic [3:0]          w_opcode;
    logic                w_is_alu;
    logic                w_is_load;
    logic                w_is_store;
    logic                w_is_jump;
    logic                w_is_beq;
    logic                w_is_exec;
    logic                w_retire;
    logic                w_ir_en;
    logic                w_alu_en;
    logic                w_mem_rd;
    logic                w_mem_wr;
    logic                w_reg_wr;
    logic                w_halted;

    assign w_opcode   = r_ir[15:12];
    assign w_target   = ADDR_W'(r_ir[3:0]);
    assign w_pc_inc   = r_pc + ADDR_W'(1);

    assign w_is_alu   = (w_opcode == c_OP_ADD)  || (w_opcode == c_OP_ALU4) ||
                        (w_opcode == c_OP_ALU5) || (w_opcode == c_OP_ALU6);
    assign w_is_load  = (w_opcode == c_OP_LOAD);
    assign w_is_store = (w_opcode == c_OP_STORE);
    assign w_is_jump  = (w_opcode == c_OP_JUMP);
    assign w_is_beq   = (w_opcode == c_OP_BEQ);
    assign w_is_exec  = w_is_alu || w_is_load || w_is_store || w_is_jump || w_is_beq;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_pc      <= '0;
            r_ir      <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc_next;
            if (w_ir_en) begin
                r_ir <= instruction;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_pc_next = r_pc;
        w_retire  = 1'b0;
        w_ir_en   = 1'b0;
        w_alu_en  = 1'b0;
        w_mem_rd  = 1'b0;
        w_mem_wr  = 1'b0;
        w_reg_wr  = 1'b0;
        w_halted  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_en = 1'b1;
                w_next  = S_DECODE;
            end
            S_DECODE: begin
                if (w_is_exec) begin
                    w_next = S_EXEC;
                end else if (w_opcode == c_OP_HALT) begin
                    w_next = S_HALT;
                end else begin
                    w_pc_next = w_pc_inc;
                    w_retire  = 1'b1;
                    w_next    = S_FETCH;
                end
            end
            S_EXEC: begin
                w_alu_en = 1'b1;
                if (w_is_alu) begin
                    w_next = S_WB;
                end else if (w_is_load || w_is_store) begin
                    w_next = S_MEM;
                end else begin
                    // JUMP and BEQ resolve here; BEQ falls through when not equal
                    w_pc_next = (w_is_jump || zero_flag) ? w_target : w_pc_inc;
                    w_retire  = 1'b1;
                    w_next    = S_FETCH;
                end
            end
            S_MEM: begin
                w_mem_rd = w_is_load;
                w_mem_wr = w_is_store;
                if (mem_ready) begin
                    if (w_is_load) begin
                        w_next = S_WB;
                    end else begin
                        w_pc_next = w_pc_inc;
                        w_retire  = 1'b1;
                        w_next    = S_FETCH;
                    end
                end
            end
            S_WB: begin
                w_reg_wr  = 1'b1;
                w_pc_next = w_pc_inc;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    assign pc_addr    = r_pc;
    assign ir         = r_ir;
    assign alu_op     = r_ir[15:12];
    assign retired    = r_retired;
    assign state      = r_state;
    assign ir_enable  = w_ir_en;
    assign alu_enable = w_alu_en;
    assign mem_read   = w_mem_rd;
    assign mem_write  = w_mem_wr;
    assign reg_write  = w_reg_wr;
    assign halted     = w_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_sequencer
//  Purpose  : Scoreboard bench for fetch_sequencer; one expectation per
//             instruction, compared when the next fetch begins.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instruction;
    logic        zero_flag = 1'b0;
    logic        mem_ready = 1'b0;
    logic [3:0]  pc_addr;
    logic        ir_enable;
    logic [15:0] ir;
    logic        alu_enable;
    logic [3:0]  alu_op;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        halted;
    logic [2:0]  state;
    logic [7:0]  retired;

    logic [15:0] mem [16];
    assign instruction = mem[pc_addr];

    fetch_sequencer #(.ADDR_W(4), .INSTR_W(16), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .instruction(instruction),
        .zero_flag  (zero_flag),
        .mem_ready  (mem_ready),
        .pc_addr    (pc_addr),
        .ir_enable  (ir_enable),
        .ir         (ir),
        .alu_enable (alu_enable),
        .alu_op     (alu_op),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .halted     (halted),
        .state      (state),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc; int pc; int ret; int irv; int alu; int mr; int mw; int rw;
    } exp_t;
    exp_t q[$];

    int n_pass  = 0;
    int n_total = 0;
    int stall   = 0;
    int mcnt    = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    task automatic push_exp(input int cyc, input int pc, input int ret, input int irv,
                            input int alu, input int mr, input int mw, input int rw);
        exp_t e;
        e.cyc = cyc; e.pc = pc; e.ret = ret; e.irv = irv;
        e.alu = alu; e.mr = mr; e.mw = mw; e.rw = rw;
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(tag, q.size(), 0);
        q.delete();
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 16; i++) mem[i] = v;
    endtask

    // Data-memory responder: holds mem_ready low for `stall` MEM cycles
    always @(negedge clk) begin
        if (state == 3'd3) begin
            mem_ready = (mcnt >= stall);
            mcnt++;
        end else begin
            mem_ready = 1'b0;
            mcnt = 0;
        end
    end

    // Instruction monitor
    bit in_instr = 0;
    int m_cyc, m_alu, m_mr, m_mw, m_rw, m_sum;
    always @(negedge clk) begin
        m_sum = int'(ir_enable) + int'(alu_enable) + int'(mem_read) +
                int'(mem_write) + int'(reg_write);
        chk("strobe_excl", int'(m_sum <= 1), 1);
        if (reset) begin
            in_instr = 0;
        end else if (ir_enable) begin
            if (in_instr && q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("latency",   m_cyc,        e.cyc);
                chk("pc",        int'(pc_addr), e.pc);
                chk("retired",   int'(retired), e.ret);
                chk("ir",        int'(ir),      e.irv);
                chk("alu_op",    int'(alu_op),  e.irv >> 12);
                chk("alu_cnt",   m_alu,        e.alu);
                chk("mrd_cnt",   m_mr,         e.mr);
                chk("mwr_cnt",   m_mw,         e.mw);
                chk("rwr_cnt",   m_rw,         e.rw);
            end
            in_instr = 1;
            m_cyc = 1; m_alu = 0; m_mr = 0; m_mw = 0; m_rw = 0;
        end else if (in_instr) begin
            m_cyc++;
            m_alu += int'(alu_enable);
            m_mr  += int'(mem_read);
            m_mw  += int'(mem_write);
            m_rw  += int'(reg_write);
        end
    end

    initial begin
        int n;
        fill(16'hF000);

        // ALU op with reset-state checks
        mem[0] = 16'h0016;
        do_reset();
        chk("rst_pc", int'(pc_addr), 0);
        chk("rst_ir", int'(ir), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_retired", int'(retired), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_ir_enable", int'(ir_enable), 1);
        chk("rst_other_strobes", int'({alu_enable, mem_read, mem_write, reg_write}), 0);
        push_exp(4, 1, 1, 'h0016, 1, 0, 0, 1);
        drain("drain_alu", 50);

        // STORE then LOAD, stalled and unstalled
        for (int s = 0; s < 2; s++) begin
            stall = (s == 0) ? 3 : 0;
            fill(16'hF000);
            mem[0] = 16'hA016;
            mem[1] = 16'h9516;
            do_reset();
            push_exp(4 + stall, 1, 1, 'hA016, 1, 0, stall + 1, 0);
            push_exp(5 + stall, 2, 2, 'h9516, 1, stall + 1, 0, 1);
            drain("drain_ldst", 100);
        end
        stall = 0;

        // JUMP then BEQ, not taken and taken
        for (int z = 0; z < 2; z++) begin
            fill(16'hF000);
            mem[0] = 16'h1000; mem[1] = 16'h1000; mem[2] = 16'h1000;
            mem[3] = 16'hB00A;
            mem[10] = 16'h70F2;
            zero_flag = (z == 1);
            do_reset();
            push_exp(2, 1, 1, 'h1000, 0, 0, 0, 0);
            push_exp(2, 2, 2, 'h1000, 0, 0, 0, 0);
            push_exp(2, 3, 3, 'h1000, 0, 0, 0, 0);
            push_exp(3, 10, 4, 'hB00A, 1, 0, 0, 0);
            push_exp(3, (z == 1) ? 2 : 11, 5, 'h70F2, 1, 0, 0, 0);
            drain("drain_branch", 100);
        end
        zero_flag = 1'b0;

        // 256 NOPs: PC wraps every 16, retired wraps at 256
        fill(16'h1000);
        do_reset();
        for (int i = 0; i < 256; i++)
            push_exp(2, (i + 1) % 16, (i + 1) % 256, 'h1000, 0, 0, 0, 0);
        drain("drain_nop", 1500);

        // HALT holds, then reset from HALT
        fill(16'hF000);
        mem[0] = 16'h1000; mem[1] = 16'h1000; mem[2] = 16'hF000;
        do_reset();
        push_exp(2, 1, 1, 'h1000, 0, 0, 0, 0);
        push_exp(2, 2, 2, 'h1000, 0, 0, 0, 0);
        drain("drain_halt_prog", 50);
        n = 0;
        while (!halted && n < 10) begin @(negedge clk); n++; end
        chk("halt_reached", int'(halted), 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("halt_flag", int'(halted), 1);
            chk("halt_pc", int'(pc_addr), 2);
            chk("halt_state", int'(state), 5);
            chk("halt_retired", int'(retired), 2);
            chk("halt_strobes", int'({ir_enable, alu_enable, mem_read, mem_write, reg_write}), 0);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("halt_rst_pc", int'(pc_addr), 0);
        chk("halt_rst_state", int'(state), 0);
        chk("halt_rst_halted", int'(halted), 0);
        reset = 1'b0;

        // Reset during a stalled MEM phase
        fill(16'hF000);
        mem[0] = 16'hA016;
        stall = 50;
        do_reset();
        n = 0;
        while (state != 3'd3 && n < 20) begin @(negedge clk); n++; end
        chk("reach_mem", int'(state), 3);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk("mem_stall_write", int'(mem_write), 1);
        @(posedge clk); #1;
        chk("mem_rst_pc", int'(pc_addr), 0);
        chk("mem_rst_state", int'(state), 0);
        chk("mem_rst_halted", int'(halted), 0);
        chk("mem_rst_write", int'(mem_write), 0);
        chk("mem_rst_ir_enable", int'(ir_enable), 1);
        reset = 1'b0;
        stall = 0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle control FSM that sequences the 16-entry instruction memory and the execute datapath. It owns the program counter, drives the memory address and IR_enable, and latches the instruction register. It decodes the 4-bit opcode and issues one-cycle ALU, memory and register-writeback strobes. It also resolves JUMP and branch-if-equal, and halts on opcode 1111.

Parameters:
ADDR_W, 4, program counter / instruction memory address width
INSTR_W, 16, instruction width
CNT_W, 8, retired-instruction counter width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
instruction  input  INSTR_W  instruction memory read data (combinational from pc_addr)
zero_flag  input  1  ALU equality result, valid during EXEC
mem_ready  input  1  data memory completion; sampled in MEM
pc_addr  output  ADDR_W  program counter, drives instruction memory addr
ir_enable  output  1  instruction fetch strobe to instruction memory
ir  output  INSTR_W  latched instruction register
alu_enable  output  1  one-cycle ALU execute strobe
alu_op  output  4  ir[15:12], forwarded to ALU
mem_read  output  1  LOAD data-memory strobe
mem_write  output  1  STORE data-memory strobe
reg_write  output  1  register-file write strobe
halted  output  1  high while in HALT
state  output  3  current FSM state encoding (debug)
retired  output  CNT_W  count of completed instructions, wraps

Behaviour:
- Reset (synchronous): pc_addr=0, ir=0, state=FETCH, retired=0, halted=0. All strobes are 0, except ir_enable, which is 1 because FETCH is entered. Reset overrides any state, including a MEM wait and HALT.
- Instruction fields: opcode=ir[15:12], rs1=ir[11:8], rs2=ir[7:4], rd_imm=ir[3:0].
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH: ir_enable=1. The ir register captures `instruction` at the clock edge. Next state is DECODE.
- DECODE, opcode classes:
  - ALU ops 0000, 0100, 0101, 0110, and LOAD 1001, STORE 1010, JUMP 1011, BEQ 0111 -> EXEC.
  - 1111 -> HALT.
  - Any other opcode is a NOP: pc_addr+1, retired+1 -> FETCH.
- EXEC: alu_enable=1 for exactly one cycle, for every opcode that reaches EXEC.
  - ALU ops -> WB.
  - LOAD / STORE -> MEM.
  - JUMP: pc_addr=rd_imm (absolute), retired+1 -> FETCH.
  - BEQ: if zero_flag=1, pc_addr=rd_imm; otherwise pc_addr+1. In both cases retired+1 -> FETCH.
- MEM: mem_read=1 (LOAD) or mem_write=1 (STORE), held every cycle while mem_ready=0.
  - When mem_ready=1: LOAD -> WB; STORE does pc_addr+1, retired+1 -> FETCH.
  - There is no timeout; a stuck mem_ready stalls indefinitely.
- WB: reg_write=1 for one cycle, pc_addr+1, retired+1 -> FETCH.
- HALT: halted=1, all strobes 0, pc_addr frozen at the HALT instruction's address. The block stays in HALT until reset.
- Latency with mem_ready=1 at first sample:
  - NOP: 2 cycles
  - JUMP / BEQ: 3 cycles
  - ALU op / STORE: 4 cycles
  - LOAD: 5 cycles
- PC arithmetic is modulo 2^ADDR_W: 15+1 wraps to 0. A jump target of 0 is legal.
- retired is modulo 2^CNT_W: 255+1 wraps to 0. HALT does not count as retired.
- ir is stable outside FETCH. It changes only at the FETCH clock edge.
- Strobe exclusivity: at most one of ir_enable, alu_enable, mem_read, mem_write, reg_write is high in any cycle.
- alu_op always equals ir[15:12] and may be ignored when alu_enable=0.

Test Plan:
- ALU op: reset, mem[0]=0x0016 (ADD). Required response:
  - ir_enable at cycle 0, alu_enable at cycle 2, reg_write at cycle 3.
  - pc_addr=1 and retired=1 at cycle 4.
- LOAD / STORE with stall: mem[0]=0xA016, mem[1]=0x9516, mem_ready low for 3 MEM cycles each. Required response:
  - mem_write high for 4 cycles, then FETCH with pc=1.
  - For the LOAD, mem_read high for 4 cycles, then reg_write, then pc=2.
- JUMP / BEQ: mem[3]=0xB00A. Then BEQ 0x70F2, run once with zero_flag=1 and once with zero_flag=0. Required response:
  - JUMP: pc=0xA after 3 cycles.
  - BEQ taken: pc=2. BEQ not taken: pc=previous PC+1.
- Wrap and NOP: mem[15]=0x1000 (NOP). Required response:
  - 2-cycle retirement, pc wraps to 0.
  - retired wraps 255->0 after 256 NOPs.
- HALT and reset: mem[2]=0xF000. Required response:
  - halted=1 and pc=2 hold for 20 cycles with no strobes.
  - reset asserted mid-MEM or in HALT gives pc=0, state=FETCH and halted=0 on the next edge.
- Strobe exclusivity is checked in every cycle of all scenarios above.
